// File: rtl/clk_sw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : clk_sw_pkg                                                 |
// | Shared state encoding and select polarity for the clock switch       |
// | sequencer.                                                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package clk_sw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      SWITCH = 2'd2
   } state_t;

   // Polarity of the glitch-free switch select input
   localparam logic SEL_CLK1 = 1'b1;
   localparam logic SEL_CLK2 = 1'b0;

endpackage
`default_nettype wire

// File: rtl/clk_activity_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clk_activity_monitor                                       |
// | Toggle flop on clk_2, synchronised into clk_1; emits a one-cycle     |
// | event on every change of the synchronised toggle.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module clk_activity_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_1,
   input  logic rst,
   input  logic clk_2,
   output logic evt_pulse
);

   logic                   r_toggle;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_q;

   // Only flop in the clk_2 domain: flips on every clk_2 rising edge
   always_ff @(posedge clk_2 or negedge rst) begin
      if (!rst) r_toggle <= 1'b0;
      else      r_toggle <= ~r_toggle;
   end

   // Synchroniser chain plus one delayed copy for change detection
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         r_sync   <= '0;
         r_sync_q <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], r_toggle};
         r_sync_q <= r_sync[SYNC_STAGES-1];
      end
   end

   assign evt_pulse = r_sync[SYNC_STAGES-1] ^ r_sync_q;

endmodule
`default_nettype wire

// File: rtl/clock_switch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : clock_switch_sequencer                                     |
// | Generates the select input of a glitch-free clock switch: proves     |
// | clk_2 alive before using it, waits for settling, monitors for loss.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module clock_switch_sequencer
   import clk_sw_pkg::*;
#(
   parameter int SYNC_STAGES       = 2,
   parameter int SETTLE_CYCLES     = 16,
   parameter int ALIVE_WINDOW      = 64,
   parameter int ALIVE_MIN_TOGGLES = 4,
   parameter int AUTO_FALLBACK     = 1,
   parameter int CNT_W             = 8
) (
   input  logic clk_1,
   input  logic rst,
   input  logic clk_2,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   output logic select,
   output logic busy,
   output logic done,
   output logic err,
   output logic clk2_lost
);

   localparam logic [CNT_W-1:0] c_window  = CNT_W'(ALIVE_WINDOW);
   localparam logic [CNT_W-1:0] c_settle  = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] c_min_evt = CNT_W'(ALIVE_MIN_TOGGLES);

   state_t           r_state, w_state_nxt;
   logic             r_select, w_select_nxt;
   logic             r_target, w_target_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;      // CHECK window / SWITCH settle
   logic [CNT_W-1:0] r_evt, w_evt_nxt;      // CHECK activity events
   logic [CNT_W-1:0] r_idle, w_idle_nxt;    // cycles since last clk_2 event
   logic [CNT_W-1:0] w_evt_inc, w_win_inc;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic             r_lost;
   logic             w_event, w_mon_active, w_loss_fire;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   clk_activity_monitor #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_mon (
      .clk_1     (clk_1),
      .rst       (rst),
      .clk_2     (clk_2),
      .evt_pulse (w_event)
   );

   // Loss monitoring only matters while parked on clk_2 with nothing in flight
   assign w_mon_active = (r_state == IDLE) && (r_select == SEL_CLK2);
   assign w_loss_fire  = w_mon_active && (r_idle >= c_window);

   assign req_ready = (r_state == IDLE) && !w_loss_fire;
   assign select    = r_select;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign err       = r_err;
   assign clk2_lost = r_lost;

   // Next-state, counter and pulse decode
   always_comb begin
      w_state_nxt  = r_state;
      w_select_nxt = r_select;
      w_target_nxt = r_target;
      w_cnt_nxt    = r_cnt;
      w_evt_nxt    = r_evt;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_evt_inc    = w_event ? sat_inc(r_evt) : r_evt;
      w_win_inc    = sat_inc(r_cnt);

      if (w_mon_active && !w_loss_fire && !w_event) w_idle_nxt = sat_inc(r_idle);
      else                                          w_idle_nxt = '0;

      case (r_state)
         IDLE: begin
            // Loss has priority: req_ready is low in this cycle
            if (w_loss_fire) begin
               if (AUTO_FALLBACK != 0) begin
                  w_state_nxt  = SWITCH;
                  w_target_nxt = SEL_CLK1;
                  w_cnt_nxt    = '0;
               end
            end else if (req_valid) begin
               if (req_sel == r_select) begin
                  w_done_nxt = 1'b1;
               end else if (req_sel == SEL_CLK1) begin
                  w_state_nxt  = SWITCH;
                  w_target_nxt = SEL_CLK1;
                  w_cnt_nxt    = '0;
               end else begin
                  w_state_nxt = CHECK;
                  w_cnt_nxt   = '0;
                  w_evt_nxt   = '0;
               end
            end
         end
         CHECK: begin
            w_cnt_nxt = w_win_inc;
            w_evt_nxt = w_evt_inc;
            // Success is tested first so it wins a tie with the window
            if (w_evt_inc >= c_min_evt) begin
               w_state_nxt  = SWITCH;
               w_target_nxt = SEL_CLK2;
               w_cnt_nxt    = '0;
            end else if (w_win_inc >= c_window) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end
         end
         SWITCH: begin
            if (r_cnt == '0) w_select_nxt = r_target;
            w_cnt_nxt = sat_inc(r_cnt);
            if (r_cnt >= c_settle) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath registers; reset forces clk_1 immediately
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_select <= SEL_CLK1;
         r_target <= SEL_CLK1;
         r_cnt    <= '0;
         r_evt    <= '0;
         r_idle   <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_lost   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_select <= w_select_nxt;
         r_target <= w_target_nxt;
         r_cnt    <= w_cnt_nxt;
         r_evt    <= w_evt_nxt;
         r_idle   <= w_idle_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_lost   <= w_loss_fire;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_switch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_clock_switch_sequencer                                  |
// | Directed and randomized checks of clock_switch_sequencer against a   |
// | latency/selection model.                                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_clock_switch_sequencer;

   localparam int SETTLE = 16;
   localparam int WINDOW = 64;
   localparam int SYNC   = 2;

   logic clk_1 = 1'b0, clk_2 = 1'b0, rst = 1'b0;
   logic req_valid = 1'b0, req_sel = 1'b1;
   logic req_ready, select, busy, done, err, clk2_lost;
   logic nf_req_ready, nf_select, nf_busy, nf_done, nf_err, nf_lost;

   int   clk2_half = 7;
   bit   clk2_run  = 1'b1;
   int   cyc = 0, checks = 0, errors = 0;
   int   n_done = 0, n_err = 0;
   logic m_select = 1'b1;   // model: which clock should be selected

   always #5 clk_1 = ~clk_1;

   always begin
      if (clk2_run) begin
         #(clk2_half) clk_2 = ~clk_2;
      end else begin
         clk_2 = 1'b0;
         #5;
      end
   end

   always @(posedge clk_1) cyc <= cyc + 1;

   clock_switch_sequencer #(.AUTO_FALLBACK(1)) dut (
      .clk_1(clk_1), .rst(rst), .clk_2(clk_2), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .select(select), .busy(busy), .done(done), .err(err),
      .clk2_lost(clk2_lost));

   clock_switch_sequencer #(.AUTO_FALLBACK(0)) dut_nf (
      .clk_1(clk_1), .rst(rst), .clk_2(clk_2), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(nf_req_ready), .select(nf_select), .busy(nf_busy), .done(nf_done),
      .err(nf_err), .clk2_lost(nf_lost));

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_1);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return done;
         1:       return err;
         2:       return select;
         3:       return clk2_lost;
         4:       return ~busy & ~req_ready;
         default: return req_ready;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int which, input logic val,
                           input int bound, output int at);
      int t = 0;
      while (sig(which) !== val && t < bound) begin
         tick();
         t++;
      end
      at = cyc;
      chk_b({tag, "_seen"}, sig(which), val);
   endtask

   // done and err must never coincide; also tally pulses
   always @(posedge clk_1) begin
      #1;
      if (rst === 1'b1) begin
         chk_b("done_err_excl", done & err, 1'b0);
         if (done) n_done++;
         if (err)  n_err++;
      end
   end

   task automatic request(input logic sel, input bit alive);
      int t0, ts, td, d0, e0;
      req_valid = 1'b1;
      req_sel   = sel;
      wait_sig("ready", 5, 1'b1, 300, t0);
      tick();
      req_valid = 1'b0;
      t0 = cyc;
      d0 = n_done;
      e0 = n_err;
      if (sel === m_select) begin
         chk_b("same_done", done, 1'b1);
         chk_b("same_sel", select, m_select);
      end else if (sel) begin
         chk_b("sw1_busy", busy, 1'b1);
         chk_b("sw1_hold", select, 1'b0);
         tick();
         chk_b("sw1_sel", select, 1'b1);
         ts = cyc;
         wait_sig("sw1_done", 0, 1'b1, SETTLE + 5, td);
         chk_i("sw1_lat", td - ts, SETTLE);
         m_select = 1'b1;
      end else if (alive) begin
         wait_sig("sw2_sel", 2, 1'b0, WINDOW + 5, ts);
         chk_b("sw2_in_window", (ts - t0) <= WINDOW + 1, 1'b1);
         wait_sig("sw2_done", 0, 1'b1, SETTLE + 5, td);
         chk_i("sw2_lat", td - ts, SETTLE);
         chk_i("sw2_no_err", n_err - e0, 0);
         m_select = 1'b0;
      end else begin
         wait_sig("chk_err", 1, 1'b1, WINDOW + 5, td);
         chk_i("chk_err_lat", td - t0, WINDOW);
         chk_b("chk_err_sel", select, 1'b1);
         chk_i("chk_err_nodone", n_done - d0, 0);
      end
      chk_b("req_end_idle", busy, 1'b0);
   endtask

   initial begin
      int t, ts, td;
      bit bad, alive;
      logic s;

      // ---- reset with clk_2 running ----
      repeat (3) tick();
      chk_b("rst_sel", select, 1'b1);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      chk_b("rst_err", err, 1'b0);
      chk_b("rst_lost", clk2_lost, 1'b0);
      @(negedge clk_1) rst = 1'b1;
      repeat (4) tick();
      chk_b("post_rst_ready", req_ready, 1'b1);
      chk_b("post_rst_sel", select, 1'b1);
      chk_i("post_rst_pulses", n_done + n_err, 0);

      // ---- asynchronous reset mid-CHECK ----
      clk2_run = 1'b0;
      repeat (5) tick();
      req_valid = 1'b1; req_sel = 1'b0;
      tick();
      req_valid = 1'b0;
      chk_b("chk_busy", busy, 1'b1);
      repeat (5) tick();
      #2 rst = 1'b0;
      #1;
      chk_b("arst_chk_busy", busy, 1'b0);
      chk_b("arst_chk_sel", select, 1'b1);
      @(negedge clk_1) rst = 1'b1;
      tick();

      // ---- asynchronous reset right after switching to clk_2 ----
      clk2_run = 1'b1;
      repeat (4) tick();
      req_valid = 1'b1; req_sel = 1'b0;
      tick();
      req_valid = 1'b0;
      wait_sig("pre_sel", 2, 1'b0, WINDOW + 5, t);
      #2 rst = 1'b0;
      #1;
      chk_b("arst_sw_sel", select, 1'b1);
      chk_b("arst_sw_busy", busy, 1'b0);
      @(negedge clk_1) rst = 1'b1;
      tick();
      m_select = 1'b1;

      // ---- switch to clk_2 (14 ns) and back; same-select request ----
      clk2_half = 7;
      request(1'b0, 1'b1);
      request(1'b1, 1'b1);
      request(1'b1, 1'b1);
      chk_b("same_busy_low", busy, 1'b0);
      request(1'b0, 1'b1);

      // ---- request held while busy ----
      req_valid = 1'b1; req_sel = 1'b1;
      tick();
      chk_b("hold_acc_busy", busy, 1'b1);
      req_sel = 1'b0;
      bad = 1'b0; t = 0;
      while (busy && t < 40) begin
         if (req_ready) bad = 1'b1;
         tick();
         t++;
      end
      chk_b("hold_ready_low", bad, 1'b0);
      chk_b("hold_done", done, 1'b1);
      chk_b("hold_sel", select, 1'b1);
      chk_b("hold_ready_now", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk_b("held_taken", busy, 1'b1);
      wait_sig("held_sel", 2, 1'b0, WINDOW + 5, ts);
      wait_sig("held_done", 0, 1'b1, SETTLE + 5, td);
      chk_i("held_lat", td - ts, SETTLE);
      m_select = 1'b0;

      // ---- clk_2 loss: fallback versus no fallback ----
      clk2_run = 1'b0;
      ts = cyc;
      wait_sig("lost", 3, 1'b1, WINDOW + 20, td);
      chk_b("lost_min", (td - ts) >= WINDOW - 3, 1'b1);
      chk_b("lost_max", (td - ts) <= WINDOW + SYNC + 5, 1'b1);
      chk_b("nf_lost", nf_lost, 1'b1);
      chk_b("fb_busy", busy, 1'b1);
      chk_b("nf_busy", nf_busy, 1'b0);
      tick();
      chk_b("lost_pulse", clk2_lost, 1'b0);
      chk_b("fb_sel", select, 1'b1);
      ts = cyc;
      wait_sig("fb_done", 0, 1'b1, SETTLE + 5, td);
      chk_i("fb_lat", td - ts, SETTLE);
      chk_b("nf_sel", nf_select, 1'b0);
      chk_b("nf_no_done", nf_done, 1'b0);
      chk_b("nf_no_err", nf_err, 1'b0);
      chk_b("nf_ready", nf_req_ready, 1'b1);
      m_select = 1'b1;

      // ---- loss coinciding with a request ----
      clk2_run = 1'b1;
      clk2_half = int'($urandom_range(7, 30));
      request(1'b0, 1'b1);
      clk2_run = 1'b0;
      wait_sig("loss_cycle", 4, 1'b1, WINDOW + 20, t);
      req_valid = 1'b1; req_sel = 1'b1;
      tick();
      chk_b("co_lost", clk2_lost, 1'b1);
      chk_b("co_busy", busy, 1'b1);
      chk_b("co_ready", req_ready, 1'b0);
      bad = 1'b0; t = 0;
      while (busy && t < 40) begin
         if (req_ready) bad = 1'b1;
         tick();
         t++;
      end
      chk_b("co_ready_low", bad, 1'b0);
      chk_b("co_fb_done", done, 1'b1);
      chk_b("co_sel", select, 1'b1);
      chk_b("co_ready_idle", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk_b("co_req_done", done, 1'b1);
      chk_b("co_req_idle", busy, 1'b0);
      m_select = 1'b1;

      // ---- randomized request sequence ----
      for (int i = 0; i < 12; i++) begin
         clk2_half = int'($urandom_range(7, 30));
         s = 1'($urandom_range(0, 1));
         alive = (m_select == 1'b0) || ($urandom_range(0, 3) != 0);
         clk2_run = alive;
         repeat (10) tick();
         request(s, alive);
         chk_b("rnd_sel", select, m_select);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
